// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: digit codes,
// active-low glyph patterns {g..a} and the code-to-glyph lookup.
package seg_pkg;

    localparam logic [4:0] CODE_BLANK = 5'd16;
    localparam logic [4:0] CODE_DASH  = 5'd17;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ERR   = 7'b1010101;

    // Hex glyphs, entry 15 (F) first so GLYPH_HEX[n] is digit n.
    localparam logic [15:0][6:0] GLYPH_HEX = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic logic [6:0] glyph_lookup(input logic [4:0] code);
        logic [6:0] pattern;
        if (code < 5'd16)
            pattern = GLYPH_HEX[code[3:0]];
        else if (code == CODE_BLANK)
            pattern = SEG_BLANK;
        else if (code == CODE_DASH)
            pattern = SEG_DASH;
        else
            pattern = SEG_ERR;
        return pattern;
    endfunction

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational digit-code to segment-pattern decode.
module seg_glyph_rom
    import seg_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] pattern
);

    always_comb pattern = glyph_lookup(code);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner: digit dwell timing, PWM brightness,
// per-digit blink and leading-zero suppression, with registered outputs.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV_LOG2     = 17,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic                    lz_suppress,
    input  logic [3:0]              brightness,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int FRM_W = $clog2(BLINK_FRAMES + 1);

    logic [DIV_LOG2-1:0]   phase;
    logic [IDX_W-1:0]      idx;
    logic [FRM_W-1:0]      frame_cnt;
    logic                  blink_phase;

    logic                  phase_wrap;
    logic                  last_digit;
    logic                  frame_end;
    logic [4:0]            cur_code;
    logic [4:0]            rom_code;
    logic [6:0]            glyph;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  lit;
    logic [NUM_DIGITS-1:0] an_next;
    logic                  dp_next;

    assign phase_wrap = &phase;
    assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
    assign frame_end  = phase_wrap && last_digit;

    // lz_mask[i]: digit i is a zero with only zeros/blanks above it.
    always_comb begin
        logic lead;
        lz_mask = '0;
        lead    = 1'b1;
        for (int j = NUM_DIGITS - 1; j >= 1; j--) begin
            lz_mask[j] = lead && (digits[5*j +: 5] == 5'd0);
            lead       = lead && ((digits[5*j +: 5] == 5'd0) ||
                                  (digits[5*j +: 5] == CODE_BLANK));
        end
    end

    always_comb begin
        cur_code = digits[5*int'(idx) +: 5];
        rom_code = (lz_suppress && lz_mask[idx]) ? CODE_BLANK : cur_code;
    end

    seg_glyph_rom u_glyph_rom (
        .code    (rom_code),
        .pattern (glyph)
    );

    always_comb begin
        lit     = (phase[DIV_LOG2-1 -: 4] <= brightness) &&
                  !(blink_en[idx] && blink_phase);
        an_next = '1;
        dp_next = 1'b1;
        if (lit) begin
            an_next = ~(NUM_DIGITS'(1) << idx);
            dp_next = ~dp_in[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            frame_done  <= 1'b0;
            seg         <= SEG_BLANK;
            an          <= '1;
            dp          <= 1'b1;
        end else begin
            phase      <= phase + 1'b1;
            frame_done <= frame_end;
            if (phase_wrap)
                idx <= last_digit ? '0 : idx + 1'b1;
            if (frame_end) begin
                if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
            seg <= glyph;
            an  <= an_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized scoreboard bench: a time-based model of the scanner predicts
// each cycle's outputs; a monitor pops and compares them.
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int DL = 4;
    localparam int BF = 2;
    localparam int DWELL = 1 << DL;
    localparam int FRAME = DWELL * ND;

    logic          clk = 1'b0;
    logic          rst;
    logic [5*ND-1:0] digits;
    logic [ND-1:0] dp_in;
    logic [ND-1:0] blink_en;
    logic          lz_suppress;
    logic [3:0]    brightness;
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic          dp;
    logic          frame_done;

    seg_scan_ctrl #(.NUM_DIGITS(ND), .DIV_LOG2(DL), .BLINK_FRAMES(BF)) dut (
        .clk         (clk),
        .rst         (rst),
        .digits      (digits),
        .dp_in       (dp_in),
        .blink_en    (blink_en),
        .lz_suppress (lz_suppress),
        .brightness  (brightness),
        .seg         (seg),
        .an          (an),
        .dp          (dp),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]    seg;
        logic [ND-1:0] an;
        logic          dp;
        logic          fd;
        string         tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   started = 0;
    int   fd_seen = 0;

    function automatic logic [6:0] ref_glyph(input int code);
        logic [6:0] hex_tab [16];
        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        if (code < 16)       return hex_tab[code];
        else if (code == 16) return 7'b1111111;
        else if (code == 17) return 7'b0111111;
        else                 return 7'b1010101;
    endfunction

    function automatic int code_of(input logic [5*ND-1:0] d, input int i);
        return int'(d[5*i +: 5]);
    endfunction

    // Expected outputs after the edge at which t cycles have elapsed since reset.
    function automatic exp_t model(input int t, input logic [5*ND-1:0] d,
                                   input logic [ND-1:0] dpi, input logic [ND-1:0] be,
                                   input logic lz, input logic [3:0] br);
        exp_t e;
        int ph, id, code, bp;
        bit sup, lit;
        ph   = t % DWELL;
        id   = (t / DWELL) % ND;
        bp   = (t / (FRAME * BF)) % 2;
        code = code_of(d, id);
        sup  = lz && (id >= 1) && (code == 0);
        for (int j = id + 1; j < ND; j++)
            if (code_of(d, j) != 0 && code_of(d, j) != 16) sup = 0;
        lit   = (ph <= int'(br)) && !(be[id] && bp == 1);
        e.seg = sup ? 7'b1111111 : ref_glyph(code);
        e.an  = lit ? ~(ND'(1) << id) : '1;
        e.dp  = lit ? ~dpi[id] : 1'b1;
        e.fd  = (t % FRAME) == FRAME - 1;
        e.tag = $sformatf("t=%0d idx=%0d ph=%0d", t, id, ph);
        return e;
    endfunction

    function automatic logic [4:0] rand_code();
        int r = $urandom_range(0, 9);
        if (r < 4)  return 5'd0;
        if (r == 4) return 5'd16;
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin : stimulus
        int   t;
        int   forced_done;
        exp_t e;
        rst = 1'b1; digits = '0; dp_in = '0; blink_en = '0;
        lz_suppress = 1'b0; brightness = 4'hF;
        t = 0;
        forced_done = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst = (cyc < 3);
            if (!forced_done && cyc > 900 && (t % FRAME) == 2 * DWELL + 9) begin
                rst = 1'b1;
                forced_done = 1;
            end else if (cyc > 1500 && $urandom_range(0, 399) == 0) begin
                rst = 1'b1;
            end
            if (cyc < 600) begin
                blink_en = 4'b0010;
                brightness = (cyc < 300) ? 4'hF : 4'd3;
            end else if ($urandom_range(0, 63) == 0) begin
                blink_en = ND'($urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < ND; i++) digits[5*i +: 5] = rand_code();
                dp_in = ND'($urandom);
                lz_suppress = 1'($urandom);
            end
            if (cyc >= 600 && $urandom_range(0, 31) == 0)
                brightness = 4'($urandom);
            if (rst) begin
                e.seg = 7'b1111111; e.an = '1; e.dp = 1'b1; e.fd = 1'b0;
                e.tag = "reset";
                t = 0;
            end else begin
                e = model(t, digits, dp_in, blink_en, lz_suppress, brightness);
                t++;
            end
            exp_q.push_back(e);
            started = 1;
        end
        @(negedge clk);
        checks++;
        if (fd_seen < 20) begin
            failures++;
            $display("FAIL frame_count: frame_done pulses seen %0d, required at least 20", fd_seen);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (started) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL queue: no expected entry for observed output");
            end else begin
                e = exp_q.pop_front();
                if (frame_done) fd_seen++;
                if (seg !== e.seg) begin
                    failures++;
                    $display("FAIL seg %s: got %b want %b", e.tag, seg, e.seg);
                end
                checks++;
                if (an !== e.an) begin
                    failures++;
                    $display("FAIL an %s: got %b want %b", e.tag, an, e.an);
                end
                checks++;
                if (dp !== e.dp) begin
                    failures++;
                    $display("FAIL dp %s: got %b want %b", e.tag, dp, e.dp);
                end
                checks++;
                if (frame_done !== e.fd) begin
                    failures++;
                    $display("FAIL frame_done %s: got %b want %b", e.tag, frame_done, e.fd);
                end
            end
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 The block SHALL have parameter DIV_LOG2, default 17: log2 of clock cycles per digit dwell, legal range 4..24.
REQ-003 The block SHALL have parameter BLINK_FRAMES, default 250: scan frames per blink half-period, minimum 1.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk (input, 1 bit, rising-edge clock) and rst (input, 1 bit, synchronous active-high reset).
REQ-005 The block SHALL have these ports, one per line as name, direction, width, meaning:
- digits  in  5*NUM_DIGITS  digit codes; digit i is bits [5i+4:5i].
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- blink_en  in  NUM_DIGITS  per-digit blink enable.
- lz_suppress  in  1  leading-zero suppression enable.
- brightness  in  4  dwell duty level; 15 = full on.
- seg  out  7  segments {g..a}, active-low.
- an  out  NUM_DIGITS  anodes, active-low, at most one low.
- dp  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse at end of each full scan.

Function
REQ-006 Code mapping SHALL be: 0-15 hex glyphs 0..F; 16 blank (7'b1111111); 17 dash (7'b0111111); 18-31 error pattern 7'b1010101. Glyph 0 SHALL be 7'b1000000, 1 7'b1111001, 8 7'b0000000.
REQ-007 A DIV_LOG2-bit phase counter SHALL increment every cycle and wrap to 0 after all ones.
REQ-008 Digit index idx SHALL advance idx+1 on phase wrap and wrap from NUM_DIGITS-1 to 0; indices >= NUM_DIGITS SHALL never occur.
REQ-009 frame_done SHALL pulse high for exactly the cycle in which idx changes from NUM_DIGITS-1 to 0.
REQ-010 A frame counter SHALL count frame_done pulses; on reaching BLINK_FRAMES it SHALL reset to 0 and toggle blink_phase.
REQ-011 Leading-zero suppression: with lz_suppress=1, digit i (i>=1) SHALL display as blank when its code is 0 and every higher digit is 0 or 16. Digit 0 SHALL never be suppressed.
REQ-012 The anode for idx SHALL be low only when phase[DIV_LOG2-1:DIV_LOG2-4] <= brightness and not (blink_en[idx] and blink_phase=1). Otherwise all anodes SHALL be high.
REQ-013 seg and dp SHALL be registered from the current idx, digits, dp_in and suppression result, giving one-cycle latency from any input change to the outputs.
REQ-014 dp SHALL be low iff dp_in[idx]=1, independent of suppression. It SHALL be gated identically to the anode.
REQ-015 Inputs SHALL be sampled every cycle with no latching; a mid-dwell digit change SHALL appear on seg one cycle later without disturbing idx.

Reset
REQ-016 While rst=1 at a clk edge: phase=0, idx=0, frame counter=0, blink_phase=0, an=all ones, seg=7'b1111111, dp=1, frame_done=0.
REQ-017 Reset SHALL take priority over all counting, including a coincident phase wrap or frame end. The first lit digit after release SHALL be digit 0.

Structure
REQ-018 A shared package seg_pkg SHALL hold the code constants (BLANK=16, DASH=17), the glyph constants, the ERR pattern and the glyph lookup function.
REQ-019 Glyph decode SHALL be one combinational sub-module, seg_glyph_rom: 5-bit code in, 7-bit pattern out. The scan, PWM, blink and suppression logic stays in seg_scan_ctrl.

Verification (NUM_DIGITS=4, DIV_LOG2=4, BLINK_FRAMES=2)
REQ-020 Scan: digits={3,2,1,0}, brightness=15 -> an cycles 1110,1101,1011,0111, 16 cycles each; seg 7'b1000000 during an=1110; frame_done high once per 64 cycles.
REQ-021 Suppression: digits={0,0,7,0}, lz_suppress=1 -> digits 3 and 2 blank, digit 1 shows 7'b1111000, digit 0 shows 7'b1000000. With lz_suppress=0 -> digits 3 and 2 show 7'b1000000.
REQ-022 PWM: brightness=3 -> each anode low for 4 of 16 dwell cycles (phase 0-3). brightness=0 -> 1 of 16.
REQ-023 Blink: blink_en=4'b0010 -> anode 1 stays high throughout frames 3-4 and 7-8 (blink_phase=1) and is lit in frames 1-2 and 5-6; other digits are unaffected.
REQ-024 Reset mid-scan: assert rst at idx=2, phase=9 for 1 cycle -> next cycle an=1111, seg=7'b1111111, dp=1. After release, an=1110 for 16 cycles. Codes 18 and 31 show 7'b1010101; code 16 shows 7'b1111111.
